// File: rtl/byte_aligner_pkg.sv
// -----------------------------------------------------------------------------
// byte_aligner_pkg
// Shared types and helpers for the receive-side byte aligner.
//   state_t      : aligner FSM states (HUNT, VERIFY, LOCKED)
//   SYNC_DEFAULT : sync byte before rotation (8'hA5)
//   rotl8/rotr8  : 8-bit rotate left/right by a 3-bit amount
// -----------------------------------------------------------------------------
package byte_aligner_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // Rotate left: the upper byte of the doubled word shifted left is the result.
   function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] k);
      logic [15:0] d;
      d = {x, x} << k;
      return d[15:8];
   endfunction

   // Rotate right: the lower byte of the doubled word shifted right is the result.
   function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] k);
      logic [15:0] d;
      d = {x, x} >> k;
      return d[7:0];
   endfunction

endpackage

// File: rtl/byte_aligner_if.sv
// -----------------------------------------------------------------------------
// byte_aligner_if
// Byte stream in / aligned stream out bundle for byte_aligner.
//   in_valid, in_data  : rotated input byte stream and qualifier
//   out_valid, out_data: de-rotated output byte (valid only while locked)
//   out_sof            : output byte is the frame sync byte
//   locked, amt        : alignment status and recovered rotation amount
// Modports: master = stream source / result sink, slave = the aligner.
// -----------------------------------------------------------------------------
interface byte_aligner_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_sof;
   logic       locked;
   logic [2:0] amt;

   modport master (
      output in_valid,
      output in_data,
      input  out_valid,
      input  out_data,
      input  out_sof,
      input  locked,
      input  amt
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output out_valid,
      output out_data,
      output out_sof,
      output locked,
      output amt
   );

endinterface

// File: rtl/byte_rotator.sv
// -----------------------------------------------------------------------------
// byte_rotator
// Combinational rotate right of one byte by a 3-bit amount, built as a
// three-stage (1/2/4) mux barrel so each stage is a single 2:1 mux level.
//   data_i [7:0] : byte to rotate
//   amt_i  [2:0] : rotate-right amount
//   data_o [7:0] : rotated byte
// -----------------------------------------------------------------------------
module byte_rotator (
   input  logic [7:0] data_i,
   input  logic [2:0] amt_i,
   output logic [7:0] data_o
);

   logic [7:0] stage1_s;
   logic [7:0] stage2_s;

   assign stage1_s = amt_i[0] ? {data_i[0],     data_i[7:1]}   : data_i;
   assign stage2_s = amt_i[1] ? {stage1_s[1:0], stage1_s[7:2]} : stage1_s;
   assign data_o   = amt_i[2] ? {stage2_s[3:0], stage2_s[7:4]} : stage2_s;

endmodule

// File: rtl/byte_aligner.sv
// -----------------------------------------------------------------------------
// byte_aligner
// Receive-side byte aligner. Finds a rotated sync byte, recovers the rotation
// amount, verifies it over LOCK_COUNT frames, then emits de-rotated bytes with
// a start-of-frame marker. Drops lock after LOSS_COUNT consecutive bad syncs.
//
// Ports:
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high reset
//   bus        : byte_aligner_if.slave (in_valid/in_data in,
//                out_valid/out_data/out_sof/locked/amt out, all registered)
//   relock_cnt : [7:0] saturating count of LOCKED->HUNT transitions
//                (present only when BYTE_ALIGNER_STATS_EN is defined)
//
// Optional build macro: BYTE_ALIGNER_STATS_EN
// -----------------------------------------------------------------------------
module byte_aligner
   import byte_aligner_pkg::*;
#(
   parameter logic [7:0] SYNC_PATTERN = SYNC_DEFAULT,
   parameter int         FRAME_LEN    = 8,
   parameter int         LOCK_COUNT   = 3,
   parameter int         LOSS_COUNT   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   byte_aligner_if.slave        bus
`ifdef BYTE_ALIGNER_STATS_EN
   ,
   output logic [7:0]           relock_cnt
`endif
);

   localparam logic [7:0] POS_LAST_C  = 8'(FRAME_LEN - 1);
   localparam logic [3:0] LOCK_CNT_C  = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_CNT_C  = 4'(LOSS_COUNT);

   state_t     state_q, state_d;
   logic [7:0] pos_q, pos_d;
   logic [3:0] good_q, good_d;
   logic [3:0] miss_q, miss_d;
   logic [2:0] amt_q, amt_d;
   logic       locked_q;
   logic       out_valid_q;
   logic       out_sof_q;
   logic [7:0] out_data_q;

   logic [7:0] match_vec_s;
   logic       hit_s;
   logic [2:0] hit_amt_s;
   logic       boundary_s;
   logic       sync_ok_s;
   logic [7:0] pos_next_s;
   logic [7:0] rot_data_s;

   // Compare bank: one equality check per possible rotation of the sync byte.
   always_comb begin
      match_vec_s = 8'd0;
      for (int k = 0; k < 8; k++) begin
         match_vec_s[k] = (bus.in_data == rotl8(SYNC_PATTERN, 3'(k)));
      end
   end

   // Priority encoder: scanning from the top down leaves the lowest match.
   always_comb begin
      hit_amt_s = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         hit_amt_s = match_vec_s[k] ? 3'(k) : hit_amt_s;
      end
   end

   assign hit_s      = |match_vec_s;
   assign sync_ok_s  = match_vec_s[amt_q];
   assign boundary_s = (pos_q == 8'd0);
   assign pos_next_s = (pos_q == POS_LAST_C) ? 8'd0 : pos_q + 8'd1;

   // Next-state logic: hunt, verify and lock tracking, only on valid bytes.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      good_d  = good_q;
      miss_d  = miss_q;
      amt_d   = amt_q;
      if (bus.in_valid) begin
         case (state_q)
            HUNT: begin
               if (hit_s) begin
                  amt_d  = hit_amt_s;
                  pos_d  = 8'd1;
                  good_d = 4'd1;
                  miss_d = 4'd0;
                  if (LOCK_CNT_C == 4'd1) begin
                     state_d = LOCKED;
                  end else begin
                     state_d = VERIFY;
                  end
               end else begin
                  state_d = HUNT;
               end
            end
            VERIFY: begin
               pos_d = pos_next_s;
               if (boundary_s) begin
                  if (sync_ok_s) begin
                     good_d = good_q + 4'd1;
                     if ((good_q + 4'd1) == LOCK_CNT_C) begin
                        state_d = LOCKED;
                        miss_d  = 4'd0;
                     end else begin
                        state_d = VERIFY;
                     end
                  end else begin
                     // The failing byte is not re-searched as a new candidate.
                     state_d = HUNT;
                     good_d  = 4'd0;
                  end
               end else begin
                  state_d = VERIFY;
               end
            end
            LOCKED: begin
               pos_d = pos_next_s;
               if (boundary_s) begin
                  if (sync_ok_s) begin
                     miss_d = 4'd0;
                  end else if ((miss_q + 4'd1) == LOSS_CNT_C) begin
                     state_d = HUNT;
                     miss_d  = 4'd0;
                     good_d  = 4'd0;
                  end else begin
                     // A miss that matches another rotation leaves amt alone.
                     miss_d = miss_q + 4'd1;
                  end
               end else begin
                  state_d = LOCKED;
               end
            end
            default: begin
               state_d = HUNT;
               pos_d   = 8'd0;
               good_d  = 4'd0;
               miss_d  = 4'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // FSM state, counters and recovered amount.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= HUNT;
         pos_q    <= 8'd0;
         good_q   <= 4'd0;
         miss_q   <= 4'd0;
         amt_q    <= 3'd0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         good_q   <= good_d;
         miss_q   <= miss_d;
         amt_q    <= amt_d;
         locked_q <= (state_d == LOCKED);
      end
   end

   byte_rotator u_rotator (
      .data_i (bus.in_data),
      .amt_i  (amt_q),
      .data_o (rot_data_s)
   );

   // Output register: valid/sof follow the pre-update state, so the byte
   // that completes lock is not emitted and the byte that drops it is.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_data_q  <= 8'd0;
      end else begin
         out_valid_q <= bus.in_valid && (state_q == LOCKED);
         out_sof_q   <= bus.in_valid && (state_q == LOCKED) && boundary_s;
         if (bus.in_valid) begin
            out_data_q <= rot_data_s;
         end else begin
            out_data_q <= out_data_q;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.out_data  = out_data_q;
   assign bus.locked    = locked_q;
   assign bus.amt       = amt_q;

`ifdef BYTE_ALIGNER_STATS_EN
   logic [7:0] relock_q, relock_d;

   // Saturating count of lock losses.
   always_comb begin
      relock_d = relock_q;
      if ((state_q == LOCKED) && (state_d == HUNT) && (relock_q != 8'hFF)) begin
         relock_d = relock_q + 8'd1;
      end else begin
         relock_d = relock_q;
      end
   end

   // Lock-loss counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         relock_q <= 8'd0;
      end else begin
         relock_q <= relock_d;
      end
   end

   assign relock_cnt = relock_q;
`endif

endmodule

// File: tb/tb_byte_aligner.sv
// -----------------------------------------------------------------------------
// tb_byte_aligner
// Directed plus randomized stimulus for byte_aligner, checked every clock
// against a frame-level reference model of the alignment rules.
// -----------------------------------------------------------------------------
module tb_byte_aligner;

   localparam logic [7:0] SYNC  = 8'hA5;
   localparam int         FRAME = 8;
   localparam int         LOCKN = 3;
   localparam int         LOSSN = 2;

   logic clk = 1'b0;
   logic reset;

   byte_aligner_if bus ();

`ifdef BYTE_ALIGNER_STATS_EN
   logic [7:0] relock_cnt;
`endif

   byte_aligner #(
      .SYNC_PATTERN (SYNC),
      .FRAME_LEN    (FRAME),
      .LOCK_COUNT   (LOCKN),
      .LOSS_COUNT   (LOSSN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus)
`ifdef BYTE_ALIGNER_STATS_EN
      ,
      .relock_cnt (relock_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: alignment status as the rules describe it.
   int         m_locked, m_verify, m_amt, m_cnt, m_good, m_miss, m_relock;
   logic       e_valid, e_sof;
   logic [7:0] e_data;

   function automatic logic [7:0] m_rotl(input logic [7:0] x, input int k);
      int v;
      v = int'(x);
      return 8'(((v << k) | (v >> (8 - k))) & 255);
   endfunction

   function automatic logic [7:0] m_rotr(input logic [7:0] x, input int k);
      return m_rotl(x, (8 - k) % 8);
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_verify = 0; m_amt = 0; m_cnt = 0;
      m_good = 0; m_miss = 0; m_relock = 0;
      e_valid = 1'b0; e_sof = 1'b0; e_data = 8'd0;
   endtask

   task automatic model_byte(input logic v, input logic [7:0] d);
      int  found;
      bit  boundary;
      bit  good;
      if (!v) begin
         e_valid = 1'b0;
         e_sof   = 1'b0;
         return;
      end
      e_valid = (m_locked != 0);
      e_sof   = (m_locked != 0) && (m_cnt == 0);
      e_data  = m_rotr(d, m_amt);
      if (m_locked == 0 && m_verify == 0) begin
         found = -1;
         for (int k = 0; k < 8; k++) begin
            if (found < 0 && m_rotl(SYNC, k) == d) found = k;
         end
         if (found >= 0) begin
            m_amt = found; m_cnt = 1; m_good = 1; m_miss = 0;
            if (LOCKN == 1) m_locked = 1;
            else m_verify = 1;
         end
      end else begin
         boundary = (m_cnt == 0);
         m_cnt    = (m_cnt + 1) % FRAME;
         if (boundary) begin
            good = (d == m_rotl(SYNC, m_amt));
            if (m_verify != 0) begin
               if (good) begin
                  m_good++;
                  if (m_good >= LOCKN) begin
                     m_verify = 0; m_locked = 1; m_miss = 0;
                  end
               end else begin
                  m_verify = 0;
               end
            end else if (good) begin
               m_miss = 0;
            end else begin
               m_miss++;
               if (m_miss >= LOSSN) begin
                  m_locked = 0; m_miss = 0;
                  if (m_relock < 255) m_relock++;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("out_valid", 8'(bus.out_valid), 8'(e_valid));
      chk("out_sof",   8'(bus.out_sof),   8'(e_sof));
      chk("locked",    8'(bus.locked),    8'(m_locked));
      chk("amt",       8'(bus.amt),       8'(m_amt));
      if (e_valid) chk("out_data", bus.out_data, e_data);
`ifdef BYTE_ALIGNER_STATS_EN
      chk("relock_cnt", relock_cnt, 8'(m_relock));
`endif
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      bus.in_valid = v;
      bus.in_data  = d;
      @(posedge clk);
      #1;
      model_byte(v, d);
      check_all();
   endtask

   task automatic fill(input int n, input logic [7:0] d);
      for (int i = 0; i < n; i++) step(1'b1, d);
   endtask

   // Byte preceded by 0..2 idle cycles; idle cycles carry junk data.
   task automatic gstep(input logic [7:0] d);
      int g;
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) step(1'b0, 8'($urandom));
      step(1'b1, d);
   endtask

   task automatic gfill(input int n);
      // Values below 8'h10 never equal a rotation of 8'hA5.
      for (int i = 0; i < n; i++) gstep(8'($urandom_range(0, 15)));
   endtask

   initial begin
      int rk;
      logic [7:0] b;

      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      model_reset();
      #12;
      chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
      chk("rst_out_data",  bus.out_data,      8'd0);
      chk("rst_out_sof",   8'(bus.out_sof),   8'd0);
      chk("rst_locked",    8'(bus.locked),    8'd0);
      chk("rst_amt",       8'(bus.amt),       8'd0);
      @(negedge clk);
      reset = 1'b0;

      // Lock at amt=3 with sync 8'h2D and 8'h00 filler.
      step(1'b1, 8'h2D); fill(FRAME - 1, 8'h00);
      step(1'b1, 8'h2D); fill(FRAME - 1, 8'h00);
      chk("prelock_locked", 8'(bus.locked), 8'd0);
      step(1'b1, 8'h2D);
      chk("lock_locked", 8'(bus.locked), 8'd1);
      chk("lock_amt", 8'(bus.amt), 8'd3);
      chk("lock_byte_hidden", 8'(bus.out_valid), 8'd0);
      step(1'b1, 8'h00);
      chk("first_out_valid", 8'(bus.out_valid), 8'd1);
      chk("first_out_data", bus.out_data, 8'h00);
      chk("first_out_sof", 8'(bus.out_sof), 8'd0);
      fill(FRAME - 2, 8'h00);
      step(1'b1, 8'h2D);
      chk("sync_out_data", bus.out_data, 8'hA5);
      chk("sync_out_sof", 8'(bus.out_sof), 8'd1);

      // Single miss, then a good sync: lock holds.
      fill(FRAME - 1, 8'h00);
      step(1'b1, 8'h11);
      chk("miss1_locked", 8'(bus.locked), 8'd1);
      fill(FRAME - 1, 8'h00);
      step(1'b1, 8'h2D);
      chk("recover_locked", 8'(bus.locked), 8'd1);

      // Loss: two consecutive bad syncs; the second is still output.
      fill(FRAME - 1, 8'h00);
      step(1'b1, 8'h11);
      chk("loss_first_locked", 8'(bus.locked), 8'd1);
      fill(FRAME - 1, 8'h00);
      step(1'b1, 8'h11);
      chk("loss_locked", 8'(bus.locked), 8'd0);
      chk("loss_out_valid", 8'(bus.out_valid), 8'd1);
      chk("loss_out_data", bus.out_data, 8'h22);
`ifdef BYTE_ALIGNER_STATS_EN
      chk("loss_relock_cnt", relock_cnt, 8'd1);
`endif

      // Verify abort, then re-acquire off the old frame grid.
      step(1'b1, 8'h2D); fill(FRAME - 1, 8'h00);
      step(1'b1, 8'h11);
      chk("abort_locked", 8'(bus.locked), 8'd0);
      fill(3, 8'h00);
      step(1'b1, 8'h2D); fill(FRAME - 1, 8'h00);
      step(1'b1, 8'h2D); fill(FRAME - 1, 8'h00);
      step(1'b1, 8'h2D);
      chk("reacq_locked", 8'(bus.locked), 8'd1);

      // Reset, then lock at amt=7 with random idle gaps.
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      gstep(8'hD2); gfill(FRAME - 1);
      gstep(8'hD2); gfill(FRAME - 1);
      gstep(8'hD2);
      chk("gap_locked", 8'(bus.locked), 8'd1);
      chk("gap_amt", 8'(bus.amt), 8'd7);
      gfill(FRAME - 1);
      gstep(8'hD2);
      chk("gap_sof_data", bus.out_data, 8'hA5);
      gfill(3);

      // Asynchronous reset mid-frame, between clock edges.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h03;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 8'(bus.out_valid), 8'd0);
      chk("arst_out_data",  bus.out_data,      8'd0);
      chk("arst_out_sof",   8'(bus.out_sof),   8'd0);
      chk("arst_locked",    8'(bus.locked),    8'd0);
      chk("arst_amt",       8'(bus.amt),       8'd0);
`ifdef BYTE_ALIGNER_STATS_EN
      chk("arst_relock_cnt", relock_cnt, 8'd0);
`endif
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset = 1'b0;
      model_reset();
      gstep(8'hD2); gfill(FRAME - 1);
      gstep(8'hD2); gfill(FRAME - 1);
      chk("relock_pre_locked", 8'(bus.locked), 8'd0);
      gstep(8'hD2);
      chk("relock_locked", 8'(bus.locked), 8'd1);

      // Randomized frames: random amount, random corrupt syncs and fillers.
      rk = 0;
      for (int f = 0; f < 48; f++) begin
         if (f % 12 == 0) rk = $urandom_range(0, 7);
         b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : m_rotl(SYNC, rk);
         gstep(b);
         for (int i = 0; i < FRAME - 1; i++) gstep(8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/byte_aligner.md
# byte_aligner

Receive-side byte aligner that undoes the 8-bit rotation applied by the transmit-path barrel shifter. It detects a rotated sync byte in an incoming byte stream, recovers the rotation amount, and verifies it over several frames before locking. Once locked, it outputs de-rotated, frame-marked bytes to the downstream deframer.

## Interface
- `SYNC_PATTERN`, 8'hA5: sync byte before rotation. Must be rotationally distinct: all 8 rotations differ.
- `FRAME_LEN`, 8: valid bytes per frame, sync included. Range 2..255.
- `LOCK_COUNT`, 3: consecutive good sync bytes needed to lock. The first detection counts. Range 1..15.
- `LOSS_COUNT`, 2: consecutive missed sync bytes that drop lock. Range 1..15.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` qualifier.
- `in_data`  in  8  rotated byte stream.
- `out_valid`  out  1  aligned byte valid. Asserted only while locked.
- `out_data`  out  8  de-rotated byte.
- `out_sof`  out  1  `out_data` is the sync byte (start of frame).
- `locked`  out  1  alignment locked.
- `amt`  out  3  recovered rotation amount. The transmitter rotated left by `amt`; this block rotates right by `amt`.

## Operation
- All state advances only on `in_valid`=1 cycles. Idle cycles change nothing.
- Define rotl(x,k) as the 8-bit rotate left by k.
- A byte is a match for k when `in_data` == rotl(SYNC_PATTERN,k).
- States:
  - HUNT:
    - Compare each valid byte against all 8 rotations in parallel.
    - On a match for k: load amt←k, pos←1, good←1.
    - If LOCK_COUNT=1, go to LOCKED. Otherwise go to VERIFY.
    - With no match, stay in HUNT.
    - If several k match (illegal pattern), the lowest k wins.
  - VERIFY:
    - pos counts 0..FRAME_LEN-1 and wraps to 0.
    - A byte arriving with pos==0 is a boundary byte.
    - Boundary byte matches rotl(SYNC,amt): good++. When good reaches LOCK_COUNT, go to LOCKED.
    - Boundary byte does not match: go to HUNT. That byte is not re-searched.
    - Non-boundary bytes are not checked.
  - LOCKED:
    - Boundary byte matches: miss←0.
    - Boundary byte misses: miss++. When miss reaches LOSS_COUNT, go to HUNT and clear `locked`. That byte is still output.
    - A miss that matches a different rotation does not change amt.
- Output path:
  - out_data = rotr(in_data,amt), registered.
  - out_sof = boundary byte.
  - out_valid = in_valid while the state, before update, is LOCKED.
- The byte that completes lock is not output. Output begins with the next byte, which is pos 1.
- Reset mid-frame discards all state immediately. There is no partial-frame flush.

## Timing
- Output latency: 1 clock from an `in_valid` byte to `out_valid`/`out_data`.
- `locked` and `amt` are registered. They change on the clock edge that consumes the deciding byte.
- No backpressure. Throughput is 1 byte/clock.
- Reset values:
  - state=HUNT; pos, good, miss=0.
  - `out_valid`=0, `out_data`=0, `out_sof`=0, `locked`=0, `amt`=0.
- The compare path is 8 parallel 8-bit equality checks plus a priority encoder. It must close in one cycle.

## Configuration
- `BYTE_ALIGNER_STATS_EN`: when defined, adds output `relock_cnt` [7:0].
  - Increments on each LOCKED→HUNT transition.
  - Saturates at 255.
  - Reset value 0.
- When undefined, the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `byte_aligner_pkg` holds:
  - State enum {HUNT, VERIFY, LOCKED}.
  - Functions rotl8 and rotr8.
  - Default sync constant 8'hA5.
- The barrel shifter keeps its own rotate logic.
- Sub-module `byte_rotator`: combinational rotate right by a 3-bit amount, used for the output path.
- The FSM, counters and compare bank stay in the top level.

## Test plan
- Lock:
  - Stimulus: stream rotl(A5,3)=8'h2D every 8th byte, filler 8'h00 between.
  - Response: amt=3 and `locked`=1 after the 3rd sync. The next output is 8'h00 at pos 1. On the following sync, `out_data`=8'hA5 with `out_sof`=1.
- Verify abort:
  - Stimulus: sync 8'h2D, then 8'h11 at the next boundary.
  - Response: return to HUNT, `locked` stays 0, `out_valid` never asserts.
- Loss:
  - Stimulus: once locked at amt=3, corrupt two consecutive boundary bytes.
  - Response: the first miss keeps lock. The second drops `locked` after that byte, and the corrupted byte is still output. With stats enabled, `relock_cnt`=1.
- Single miss recovery:
  - Stimulus: locked, one bad boundary byte, then a good one.
  - Response: `locked` stays 1 and miss resets to 0.
- Gaps and reset:
  - Stimulus: random `in_valid` gaps during lock, with amt=7 (sync 8'hD2).
  - Response: lock after 3 syncs, unaffected by the gaps.
  - Stimulus: assert `reset` mid-frame.
  - Response: all outputs drop to 0 asynchronously. Re-lock requires 3 fresh syncs.
